// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder over a word-organised SRAM with programmable wait states and two-cycle ERROR.
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int DEPTH = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0] CNT0 = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  typedef enum logic [2:0] {st_idle, st_wait, st_data, st_err1, st_err2} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH];
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic [1:0] lane, size;
  logic write, ready, acc, legal, aligned;
  logic [3:0] cnt, be;
  logic unused_burst;
  assign unused_burst = ^HBURST;
  assign off = HADDR - BASE_ADDR;
  assign ready = state inside {st_idle, st_data, st_err2};
  assign acc = ready & HSEL & HREADY & HTRANS[1];
  // Sizes above word fail here, so no separate size check is needed.
  assign aligned = (HSIZE == 3'd0) || (HSIZE == 3'd1 && !off[0]) || (HSIZE == 3'd2 && off[1:0] == 2'b00);
  assign legal = aligned && off < LIMIT;
  assign be = size == 2'd2 ? 4'hf : size == 2'd1 ? (lane[1] ? 4'hc : 4'h3) : 4'b0001 << lane;
  always_comb begin
    state_nx = state;
    HREADYOUT = ready;
    HRESP = state inside {st_err1, st_err2};
    HRDATA = (state == st_data && !write) ? mem[idx] : 32'h0;
    if (ready)
      state_nx = !acc ? st_idle : !legal ? st_err1 : (WAIT_STATES > 0) ? st_wait : st_data;
    else if (state == st_wait)
      state_nx = cnt == 4'd0 ? st_data : st_wait;
    else
      state_nx = st_err2;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= st_idle;
      cnt <= 4'd0;
      idx <= '0;
      lane <= 2'd0;
      size <= 2'd0;
      write <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        idx <= off[AW+1:2];
        lane <= off[1:0];
        size <= HSIZE[1:0];
        write <= HWRITE;
        cnt <= CNT0;
      end else if (state == st_wait) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  // Reset forces state to idle asynchronously, so an interrupted write never commits.
  always_ff @(posedge clk) begin
    if (state == st_data && write)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= HWDATA[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed checks of two responders (zero and two wait states) sharing one bus.
module tb_ahb_sram_slave;
  localparam logic [1:0] ID = 2'b00, BY = 2'b01, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] B = 3'd0, H = 3'd1, W = 3'd2;
  logic clk = 1'b0, reset = 1'b1;
  logic sel, hsel, hwrite, hready;
  logic [31:0] haddr, hwdata;
  logic [1:0] htrans;
  logic [2:0] hsize, hburst;
  logic ro0, rs0, ro2, rs2, ready, resp;
  logic [31:0] rd0, rd2, rdata;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign ready = sel ? ro2 : ro0;
  assign resp = sel ? rs2 : rs0;
  assign rdata = sel ? rd2 : rd0;
  assign hready = ready;
  ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .HSEL(hsel & !sel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0));
  ahb_sram_slave #(.WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .HSEL(hsel & sel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro2), .HRESP(rs2), .HRDATA(rd2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic ph(input string tag, input logic r, input logic s);
    chk(tag, {30'd0, ready, resp}, {30'd0, r, s});
  endtask
  task automatic rd(input string tag, input logic [31:0] d);
    chk(tag, rdata, d);
  endtask
  task automatic step(input logic s, input logic [1:0] t, input logic [31:0] a, input logic w,
                      input logic [2:0] z, input logic [31:0] d);
    @(posedge clk);
    #1;
    hsel = s; htrans = t; haddr = a; hwrite = w; hsize = z; hwdata = d;
    @(negedge clk);
  endtask
  initial begin
    hsel = 0; htrans = ID; haddr = 0; hwrite = 0; hsize = W; hburst = 0; hwdata = 0; sel = 0;
    @(negedge clk);
    ph("rst_phase", 1, 0); rd("rst_rdata", 0);
    reset = 0;
    step(1, NS, 32'h10, 1, W, 0);               ph("t1_addr", 1, 0);
    step(1, NS, 32'h10, 0, W, 32'hDEADBEEF);     ph("t1_wdata", 1, 0); rd("t1_wr_rdata", 0);
    step(0, ID, 0, 0, W, 0);                    ph("t1_rd", 1, 0); rd("t1_rdata", 32'hDEADBEEF);
    step(0, ID, 0, 0, W, 0);                    rd("t1_idle_rdata", 0);
    step(1, NS, 32'h20, 1, B, 0);
    step(1, NS, 32'h21, 1, B, 32'h0000_0011);
    step(1, NS, 32'h22, 1, B, 32'h0000_2200);
    step(1, NS, 32'h23, 1, B, 32'h0033_0000);
    step(1, NS, 32'h22, 1, H, 32'h4400_0000);
    step(1, NS, 32'h20, 0, W, 32'hAAAA_0000);    ph("t3_half", 1, 0);
    step(0, ID, 0, 0, W, 0);                    rd("t3_lanes", 32'hAAAA2211);
    step(1, NS, 32'h0, 1, W, 0);
    step(0, ID, 0, 0, W, 32'hCAFEF00D);
    step(1, NS, 32'h1000, 0, W, 0);             ph("t4_pre", 1, 0);
    step(0, ID, 0, 0, W, 0);                    ph("t4_oob_err1", 0, 1);
    step(1, NS, 32'h1, 1, H, 0);                ph("t4_oob_err2", 1, 1);
    step(0, ID, 0, 0, W, 32'hFFFF_FFFF);         ph("t4_mis_err1", 0, 1);
    step(1, NS, 32'h0, 0, W, 32'hFFFF_FFFF);     ph("t4_mis_err2", 1, 1);
    step(0, ID, 0, 0, W, 0);                    ph("t4_after", 1, 0); rd("t4_unchanged", 32'hCAFEF00D);
    step(1, NS, 32'h80, 1, W, 0);
    step(1, SQ, 32'h84, 1, W, 32'h0101_0101);    ph("t5_w0", 1, 0);
    step(1, BY, 32'h88, 1, W, 32'h0202_0202);    ph("t5_w1", 1, 0);
    step(1, SQ, 32'h88, 1, W, 32'hBADB_AD00);    ph("t5_busy", 1, 0);
    step(1, SQ, 32'h8C, 1, W, 32'h0303_0303);
    step(0, NS, 32'h80, 1, W, 32'h0404_0404);
    step(0, ID, 0, 0, W, 32'hFFFF_FFFF);         ph("t5_unsel", 1, 0);
    step(1, NS, 32'h80, 0, W, 0);
    step(1, SQ, 32'h84, 0, W, 0);               rd("t5_r0", 32'h0101_0101);
    step(0, ID, 0, 0, W, 0);                    rd("t5_r1", 32'h0202_0202);
    step(1, NS, 32'h88, 0, W, 0);               rd("t5_idle", 0);
    step(1, BY, 32'h8C, 0, W, 0);               rd("t5_r2", 32'h0303_0303);
    step(1, SQ, 32'h8C, 0, W, 0);               ph("t5_busy_rd", 1, 0); rd("t5_busy_rdata", 0);
    step(0, ID, 0, 0, W, 0);                    rd("t5_r3", 32'h0404_0404);
    sel = 1;
    step(1, NS, 32'h0, 1, W, 0);                ph("t2_w_addr", 1, 0);
    step(0, ID, 0, 0, W, 32'h5A5AA5A5);          ph("t2_w_low1", 0, 0);
    step(0, ID, 0, 0, W, 32'h5A5AA5A5);          ph("t2_w_low2", 0, 0);
    step(0, ID, 0, 0, W, 32'h5A5AA5A5);          ph("t2_w_data", 1, 0);
    step(1, NS, 32'h0, 0, W, 0);                ph("t2_r_addr", 1, 0);
    step(1, NS, 32'h0, 0, W, 0);                ph("t2_r_low1", 0, 0); rd("t2_low_rdata", 0);
    step(1, NS, 32'h0, 0, W, 0);                ph("t2_r_low2", 0, 0);
    step(1, NS, 32'h0, 0, W, 0);                ph("t2_r_data", 1, 0); rd("t2_rdata", 32'h5A5AA5A5);
    step(0, ID, 0, 0, W, 0);                    ph("t2_r2_low1", 0, 0);
    step(0, ID, 0, 0, W, 0);                    ph("t2_r2_low2", 0, 0);
    step(0, ID, 0, 0, W, 0);                    ph("t2_r2_data", 1, 0); rd("t2_r2_rdata", 32'h5A5AA5A5);
    step(1, NS, 32'h40, 1, W, 0);
    step(0, ID, 0, 0, W, 32'h12345678);
    step(0, ID, 0, 0, W, 32'h12345678);
    step(0, ID, 0, 0, W, 32'h12345678);
    step(1, NS, 32'h40, 1, W, 0);
    step(0, ID, 0, 0, W, 32'hFFFF0000);          ph("t6_wait", 0, 0);
    reset = 1;
    #1;
    ph("t6_rst_phase", 1, 0); rd("t6_rst_rdata", 0);
    #1;
    reset = 0;
    step(1, NS, 32'h40, 0, W, 0);               ph("t6_post_idle", 1, 0);
    step(0, ID, 0, 0, W, 0);
    step(0, ID, 0, 0, W, 0);
    step(0, ID, 0, 0, W, 0);                    ph("t6_data", 1, 0); rd("t6_kept", 32'h12345678);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
